uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Buffered UART transmitter: accepts bytes over a valid/ready handshake into an internal FIFO and serialises them as 8N1 frames on `uart_tx`.
- Drains back-to-back with no idle gap between frames.
- Sits opposite the UART receive path and replaces ad-hoc ROM-driven transmit loops; any producer (command handler, debug dumper) pushes bytes and forgets.

Parameters:
- DELAY_FRAMES, 234, clock cycles per bit (27 MHz / 115200 baud).
- FIFO_DEPTH, 16, byte entries in the FIFO; power of two, minimum 2.

Ports:
- clk  input  1  system clock, sole clock domain.
- rst  input  1  synchronous, active-high reset.
- tx_data  input  8  byte to send.
- tx_valid  input  1  producer has a byte on `tx_data`.
- tx_ready  output  1  FIFO can accept; byte transfers when `tx_valid && tx_ready` at a rising clk edge.
- uart_tx  output  1  serial line, idle high, registered.
- busy  output  1  FIFO not empty, or a frame in progress.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (synchronous, active-high):
  - `uart_tx`=1, `tx_ready`=0 during reset, then 1 from the first cycle after reset is deasserted.
  - `busy`=0, `fifo_count`=0, FIFO pointers cleared, state=IDLE, bit counter=0, cycle counter=0.
- FIFO:
  - `tx_ready` = (`fifo_count` != FIFO_DEPTH), registered-count based. Same-cycle pop does not raise `tx_ready` when full.
  - Push when full: impossible by handshake; a `tx_valid` without `tx_ready` is ignored and the data is not stored.
  - Simultaneous push and pop: count unchanged, both take effect.
  - Pointers wrap modulo FIFO_DEPTH.
- State machine, with a cycle counter 0..DELAY_FRAMES-1:
  - IDLE: `uart_tx`=1. If FIFO not empty: pop head into the shift register, counter=0, go to START.
  - START: `uart_tx`=0 for DELAY_FRAMES cycles, then bit index=0, go to DATA.
  - DATA: `uart_tx`=shift[bit index], LSB first, for DELAY_FRAMES cycles per bit. After bit 7 go to PARITY if enabled, else STOP.
  - PARITY (optional): one bit period.
  - STOP: `uart_tx`=1 for DELAY_FRAMES cycles. At the last cycle:
    - FIFO not empty: pop and go directly to START, giving zero idle gap.
    - FIFO empty: go to IDLE.
- Timing:
  - Every bit lasts exactly DELAY_FRAMES cycles.
  - A frame lasts 10*DELAY_FRAMES cycles, or 11*DELAY_FRAMES with parity.
- Latency: a byte accepted into an empty FIFO at edge N is popped at edge N+1, and `uart_tx` falls at edge N+2.
- `busy` = (state != IDLE) || (`fifo_count` != 0), combinational from registers.
- Reset mid-frame: the line returns high on the next edge, the partial frame is abandoned and the FIFO contents are discarded.
- Counter width: $clog2(DELAY_FRAMES). No overflow is possible because the counter is compared with DELAY_FRAMES-1 before incrementing.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: an even-parity bit (XOR of the 8 data bits) is inserted between data bit 7 and the stop bit.
- Undefined: PARITY state and logic are absent and the frame is pure 8N1.

Decomposition:
- Package uart_pkg:
  - Default DELAY_FRAMES constant.
  - TX state enum: IDLE, START, DATA, PARITY, STOP.
  - Frame bit-count constants.
- Sub-module sync_fifo:
  - Parameterised width and depth.
  - Push/pop and count.
  - Synchronous active-high `rst`.

Test Plan:
- Reset, then idle for 1000 cycles -> `uart_tx`=1, `busy`=0, `tx_ready`=1, `fifo_count`=0.
- Push 0x55 at edge N -> `uart_tx` falls at N+2; line samples 0,1,0,1,0,1,0,1,0,1 at mid-bit, every 234 cycles; `busy` drops after the stop bit.
- Push 17 bytes 0x00..0x10 continuously with no pops pending:
  - `tx_ready`=0 once `fifo_count`=16.
  - All bytes are received in order by a reference UART receiver model.
  - No idle gap between stop and next start.
- Push 0xA3, assert `rst` at cycle 1000 mid-data -> `uart_tx`=1 on the next edge, `fifo_count`=0, no further frames.
- Push and wait while FIFO has 1 entry at the pop edge -> `fifo_count` unchanged.
- With UART_TX_PARITY_EN, push 0x07 -> parity bit=1, frame length 2574 cycles. Push 0x03 -> parity bit=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and types for the buffered UART transmitter.
// Build option UART_TX_PARITY_EN adds an even-parity bit to every frame.
package uart_pkg;

    localparam int unsigned DEFAULT_DELAY_FRAMES = 234;
    localparam int unsigned DEFAULT_FIFO_DEPTH   = 16;
    localparam int unsigned DATA_BITS            = 8;

`ifdef UART_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } tx_state_e;

    // Bit-period counter width; kept at least one bit wide for DELAY_FRAMES of 1.
    function automatic int unsigned cnt_width(input int unsigned delay);
        return (delay > 1) ? $clog2(delay) : 1;
    endfunction

`ifdef UART_TX_PARITY_EN
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction
`endif

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count and fall-through read of the head entry.
// DEPTH must be a power of two, at least 2; pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes enter a FIFO over valid/ready and drain
// back-to-back with no idle gap. Define UART_TX_PARITY_EN for an even-parity bit.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DELAY_FRAMES = DEFAULT_DELAY_FRAMES,
    parameter int unsigned FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        uart_tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int unsigned        CNT_W    = cnt_width(DELAY_FRAMES);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DELAY_FRAMES - 1);
    localparam logic [2:0]         BIT_LAST = 3'(DATA_BITS - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             uart_tx_q, uart_tx_d;

    logic             fifo_push;
    logic             fifo_pop;
    logic [7:0]       fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic             bit_end;

    assign tx_ready  = !rst && !fifo_full;
    assign fifo_push = tx_valid && tx_ready;
    assign bit_end   = (cnt_q == CNT_LAST);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i (tx_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Line level is derived from the current state and registered, so the
    // serial output trails the state register by exactly one cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        uart_tx_d = 1'b1;
        fifo_pop  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                uart_tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    cnt_d    = '0;
                    state_d  = ST_START;
                end
            end

            ST_START: begin
                uart_tx_d = 1'b0;
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DATA: begin
                uart_tx_d = shift_q[bit_q];
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                uart_tx_d = even_parity(shift_q);
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif

            ST_STOP: begin
                uart_tx_d = 1'b1;
                if (bit_end) begin
                    cnt_d = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            uart_tx_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            uart_tx_q <= uart_tx_d;
        end
    end

    assign uart_tx = uart_tx_q;
    assign busy    = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a mid-bit sampling reference receiver.
// Honours UART_TX_PARITY_EN to expect the extra parity bit.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int unsigned DF   = 234;
    localparam int unsigned HALF = 117;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif
    localparam int unsigned FRAME = NBITS * DF;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       uart_tx;
    logic       busy;
    logic [4:0] fifo_count;

    int unsigned vectors = 0;
    int unsigned errors  = 0;
    int unsigned cyc     = 0;

    uart_tx_fifo #(
        .DELAY_FRAMES (DF),
        .FIFO_DEPTH   (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference receiver: detect falling edge, sample each bit at mid-period.
    logic [7:0]  rx_q[$];
    logic        rx_par_q[$];
    int unsigned rx_start_q[$];
    int unsigned rx_bad = 0;
    bit          rx_active = 1'b0;

    initial begin : rx_model
        logic [7:0]  b;
        logic        p;
        int unsigned s;
        forever begin
            @(posedge clk); #1;
            if (uart_tx === 1'b0) begin
                rx_active = 1'b1;
                s = cyc;
                p = 1'b0;
                repeat (HALF) @(posedge clk);
                #1;
                if (uart_tx !== 1'b0) rx_bad++;
                for (int k = 0; k < 8; k++) begin
                    repeat (DF) @(posedge clk);
                    #1;
                    b[k] = uart_tx;
                end
`ifdef UART_TX_PARITY_EN
                repeat (DF) @(posedge clk);
                #1;
                p = uart_tx;
`endif
                repeat (DF) @(posedge clk);
                #1;
                if (uart_tx !== 1'b1) rx_bad++;
                rx_q.push_back(b);
                rx_par_q.push_back(p);
                rx_start_q.push_back(s);
                rx_active = 1'b0;
            end
        end
    end

    initial begin : watchdog
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded 150000 cycles, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic rx_flush();
        int unsigned g;
        g = 0;
        while ((rx_active || busy !== 1'b0) && g < 4 * FRAME) begin
            step(1);
            g++;
        end
        rx_q.delete();
        rx_par_q.delete();
        rx_start_q.delete();
        rx_bad = 0;
    endtask

    task automatic drain(input string name, input int unsigned limit);
        int unsigned g;
        g = 0;
        while (busy !== 1'b0 && g < limit) begin
            step(1);
            g++;
        end
        step(DF);
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain_timeout: busy=%b after %0d cycles, expected 0", name, busy, g);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tx_valid = 1'b0;
        step(3);
        vectors++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", tx_ready); end
        vectors++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_line: got %b expected 1", uart_tx); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        rst = 1'b0;
        step(1);
        vectors++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_release: got %b expected 1", tx_ready); end
        step(1000);
        vectors++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL idle_line: got %b expected 1", uart_tx); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
        vectors++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b expected 1", tx_ready); end
        vectors++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL idle_count: got %0d expected 0", fifo_count); end
    endtask

    task automatic test_single();
        logic [10:0] exp_bits;
        logic [7:0]  d;
        d = 8'h55;
        exp_bits = '1;
        exp_bits[0] = 1'b0;
        exp_bits[8:1] = d;
`ifdef UART_TX_PARITY_EN
        exp_bits[9] = ^d;
`endif
        tx_data = d;
        tx_valid = 1'b1;
        step(1);
        tx_valid = 1'b0;
        vectors++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL single_count_push: got %0d expected 1", fifo_count); end
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_push: got %b expected 1", busy); end
        vectors++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL single_line_n: got %b expected 1", uart_tx); end
        step(1);
        vectors++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL single_count_pop: got %0d expected 0", fifo_count); end
        vectors++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL single_line_n1: got %b expected 1", uart_tx); end
        step(1);
        vectors++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL single_fall_n2: got %b expected 0", uart_tx); end
        step(HALF);
        for (int k = 0; k < int'(NBITS); k++) begin
            vectors++;
            if (uart_tx !== exp_bits[k]) begin
                errors++;
                $display("FAIL single_bit%0d: got %b expected %b", k, uart_tx, exp_bits[k]);
            end
            if (k < int'(NBITS) - 1) step(DF);
        end
        step(DF - 2 - HALF);
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_stop: got %b expected 1", busy); end
        step(1);
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_done: got %b expected 0", busy); end
        vectors++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL single_line_done: got %b expected 1", uart_tx); end
    endtask

    task automatic test_fill();
        rx_flush();
        for (int i = 0; i < 17; i++) begin
            tx_data = 8'(i);
            tx_valid = 1'b1;
            vectors++;
            if (tx_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d: got %b expected 1", i, tx_ready); end
            step(1);
        end
        tx_data = 8'hEE;
        vectors++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL fill_count_full: got %0d expected 16", fifo_count); end
        vectors++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_full: got %b expected 0", tx_ready); end
        step(5);
        tx_valid = 1'b0;
        vectors++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL fill_push_ignored: got %0d expected 16", fifo_count); end
        drain("fill", 20 * FRAME);
        vectors++;
        if (rx_q.size() != 17) begin errors++; $display("FAIL fill_rx_len: got %0d expected 17", rx_q.size()); end
        for (int i = 0; i < 17; i++) begin
            vectors++;
            if (i >= rx_q.size() || rx_q[i] !== 8'(i)) begin
                errors++;
                $display("FAIL fill_rx_byte%0d: got %h expected %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, 8'(i));
            end
        end
        for (int i = 1; i < rx_start_q.size(); i++) begin
            vectors++;
            if (rx_start_q[i] - rx_start_q[i-1] != FRAME) begin
                errors++;
                $display("FAIL fill_gap%0d: got %0d cycles expected %0d", i, rx_start_q[i] - rx_start_q[i-1], FRAME);
            end
        end
        vectors++; if (rx_bad != 0) begin errors++; $display("FAIL fill_framing: got %0d errors expected 0", rx_bad); end
    endtask

    task automatic test_hold();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'hC3;
        exp_b[1] = 8'h3C;
        exp_b[2] = 8'h96;
        rx_flush();
        tx_data = exp_b[0];
        tx_valid = 1'b1;
        step(1);
        vectors++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL hold_count_first: got %0d expected 1", fifo_count); end
        tx_data = exp_b[1];
        step(1);
        tx_valid = 1'b0;
        vectors++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL hold_idle_pushpop: got %0d expected 1", fifo_count); end
        step(FRAME - 1);
        vectors++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL hold_count_prestop: got %0d expected 1", fifo_count); end
        vectors++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL hold_line_stop: got %b expected 1", uart_tx); end
        tx_data = exp_b[2];
        tx_valid = 1'b1;
        step(1);
        tx_valid = 1'b0;
        vectors++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL hold_stop_pushpop: got %0d expected 1", fifo_count); end
        step(1);
        vectors++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL hold_no_gap_fall: got %b expected 0", uart_tx); end
        drain("hold", 4 * FRAME);
        vectors++;
        if (rx_q.size() != 3) begin errors++; $display("FAIL hold_rx_len: got %0d expected 3", rx_q.size()); end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (i >= rx_q.size() || rx_q[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL hold_rx_byte%0d: got %h expected %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_b[i]);
            end
        end
        vectors++; if (rx_bad != 0) begin errors++; $display("FAIL hold_framing: got %0d errors expected 0", rx_bad); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        rx_flush();
        tx_data = 8'h07;
        tx_valid = 1'b1;
        step(1);
        tx_data = 8'h03;
        step(1);
        tx_valid = 1'b0;
        drain("parity", 4 * FRAME);
        vectors++;
        if (rx_q.size() != 2) begin errors++; $display("FAIL parity_rx_len: got %0d expected 2", rx_q.size()); end
        if (rx_q.size() == 2) begin
            vectors++; if (rx_q[0] !== 8'h07) begin errors++; $display("FAIL parity_byte0: got %h expected 07", rx_q[0]); end
            vectors++; if (rx_par_q[0] !== 1'b1) begin errors++; $display("FAIL parity_bit_07: got %b expected 1", rx_par_q[0]); end
            vectors++; if (rx_q[1] !== 8'h03) begin errors++; $display("FAIL parity_byte1: got %h expected 03", rx_q[1]); end
            vectors++; if (rx_par_q[1] !== 1'b0) begin errors++; $display("FAIL parity_bit_03: got %b expected 0", rx_par_q[1]); end
            vectors++;
            if (rx_start_q[1] - rx_start_q[0] != 2574) begin
                errors++;
                $display("FAIL parity_frame_len: got %0d expected 2574", rx_start_q[1] - rx_start_q[0]);
            end
        end
        vectors++; if (rx_bad != 0) begin errors++; $display("FAIL parity_framing: got %0d errors expected 0", rx_bad); end
    endtask
`endif

    task automatic test_reset_mid();
        int unsigned lows;
        rx_flush();
        tx_data = 8'hA3;
        tx_valid = 1'b1;
        step(1);
        tx_data = 8'h5A;
        step(1);
        tx_valid = 1'b0;
        step(998);
        vectors++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL rstmid_pre_line: got %b expected 0", uart_tx); end
        vectors++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL rstmid_pre_count: got %0d expected 1", fifo_count); end
        rst = 1'b1;
        step(1);
        vectors++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL rstmid_line: got %b expected 1", uart_tx); end
        vectors++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", fifo_count); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        vectors++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready: got %b expected 0", tx_ready); end
        rst = 1'b0;
        step(1);
        vectors++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready_release: got %b expected 1", tx_ready); end
        lows = 0;
        for (int i = 0; i < 3000; i++) begin
            step(1);
            if (uart_tx !== 1'b1) lows++;
        end
        vectors++; if (lows != 0) begin errors++; $display("FAIL rstmid_quiet: got %0d low cycles expected 0", lows); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_after: got %b expected 0", busy); end
        vectors++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL rstmid_count_after: got %0d expected 0", fifo_count); end
    endtask

    initial begin : main
        test_reset();
        test_single();
        test_fill();
        test_hold();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
